// File: rtl/mul_err_pkg.sv
// Shared types and helpers for the approximate-multiplier error monitor.
// Optional worst-operand capture is enabled with MUL_ERR_WORST_CAPTURE_EN.
package mul_err_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    localparam int DW_DEF = 8;
    localparam int PROD_W = 2 * DW_DEF;

    // Add two values and clamp to the all-ones value of a w-bit field (w <= 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] s;
        logic [63:0] lim;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        s   = {1'b0, a} + {1'b0, b};
        sat_add = (s > {1'b0, lim}) ? lim : s[63:0];
    endfunction

endpackage

// File: rtl/mul_err_pipe.sv
// Scoring pipeline: exact product, absolute error, then a register stage feeding the stats.
// With MUL_ERR_WORST_CAPTURE_EN the operands travel alongside the error.
module mul_err_pipe
    import mul_err_pkg::*;
#(
    parameter int DATA_WIDTH = DW_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    flush_i,
    input  logic                    valid_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    input  logic [2*DATA_WIDTH-1:0] prod_i,
`ifdef MUL_ERR_WORST_CAPTURE_EN
    output logic [DATA_WIDTH-1:0]   a_o,
    output logic [DATA_WIDTH-1:0]   b_o,
`endif
    output logic                    active_o,
    output logic                    valid_o,
    output logic [2*DATA_WIDTH-1:0] err_o
);
    localparam int PW = 2 * DATA_WIDTH;

    logic [3:1]    vld_pipe_q;
    logic [PW-1:0] prod1_q, exact1_q, err2_q, err3_q;
`ifdef MUL_ERR_WORST_CAPTURE_EN
    logic [DATA_WIDTH-1:0] a1_q, b1_q, a2_q, b2_q, a3_q, b3_q;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_pipe_q <= '0;
            prod1_q    <= '0;
            exact1_q   <= '0;
            err2_q     <= '0;
            err3_q     <= '0;
`ifdef MUL_ERR_WORST_CAPTURE_EN
            {a1_q, b1_q, a2_q, b2_q, a3_q, b3_q} <= '0;
`endif
        end else begin
            vld_pipe_q <= flush_i ? '0 : {vld_pipe_q[2:1], valid_i};
            if (valid_i) begin
                prod1_q  <= prod_i;
                exact1_q <= PW'(a_i) * PW'(b_i);
            end
            if (vld_pipe_q[1])
                err2_q <= (exact1_q >= prod1_q) ? exact1_q - prod1_q : prod1_q - exact1_q;
            if (vld_pipe_q[2])
                err3_q <= err2_q;
`ifdef MUL_ERR_WORST_CAPTURE_EN
            if (valid_i)       {a1_q, b1_q} <= {a_i, b_i};
            if (vld_pipe_q[1]) {a2_q, b2_q} <= {a1_q, b1_q};
            if (vld_pipe_q[2]) {a3_q, b3_q} <= {a2_q, b2_q};
`endif
        end
    end

    assign active_o = |vld_pipe_q;
    assign valid_o  = vld_pipe_q[3];
    assign err_o    = err3_q;
`ifdef MUL_ERR_WORST_CAPTURE_EN
    assign a_o = a3_q;
    assign b_o = b3_q;
`endif

endmodule

// File: rtl/mul_err_monitor.sv
// Run controller and error statistics for scoring an approximate multiplier.
// Define MUL_ERR_WORST_CAPTURE_EN to add worst_a_o/worst_b_o.
module mul_err_monitor
    import mul_err_pkg::*;
#(
    parameter int DATA_WIDTH = DW_DEF,
    parameter int CNT_WIDTH  = 32,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [CNT_WIDTH-1:0]    run_len_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DATA_WIDTH-1:0]   in_a_i,
    input  logic [DATA_WIDTH-1:0]   in_b_i,
    input  logic [2*DATA_WIDTH-1:0] in_prod_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [CNT_WIDTH-1:0]    sample_cnt_o,
    output logic [CNT_WIDTH-1:0]    mismatch_cnt_o,
    output logic [ACC_WIDTH-1:0]    err_sum_o,
`ifdef MUL_ERR_WORST_CAPTURE_EN
    output logic [DATA_WIDTH-1:0]   worst_a_o,
    output logic [DATA_WIDTH-1:0]   worst_b_o,
`endif
    output logic [2*DATA_WIDTH-1:0] err_max_o
);
    localparam int PW = 2 * DATA_WIDTH;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   run_len_q, run_len_d, acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, mm_q, mm_d;
    logic [ACC_WIDTH-1:0]   sum_q, sum_d;
    logic [PW-1:0]          max_q, max_d, err;
    logic                   in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d;
    logic                   accept, restart, pipe_active, pipe_valid;
`ifdef MUL_ERR_WORST_CAPTURE_EN
    logic [DATA_WIDTH-1:0]  wa_q, wa_d, wb_q, wb_d, pa, pb;
`endif

    assign accept = in_valid_i & in_ready_q;

    mul_err_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_pipe (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .flush_i  (clear_i),
        .valid_i  (accept),
        .a_i      (in_a_i),
        .b_i      (in_b_i),
        .prod_i   (in_prod_i),
`ifdef MUL_ERR_WORST_CAPTURE_EN
        .a_o      (pa),
        .b_o      (pb),
`endif
        .active_o (pipe_active),
        .valid_o  (pipe_valid),
        .err_o    (err)
    );

    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        acc_d     = acc_q;
        restart   = 1'b0;
        case (state_q)
            IDLE, DONE: if (start_i) begin
                state_d   = RUN;
                run_len_d = run_len_i;
                acc_d     = '0;
                restart   = 1'b1;
            end
            RUN: begin
                if (accept) acc_d = acc_q + CNT_WIDTH'(1);
                if (acc_d == run_len_q) state_d = DRAIN;
            end
            DRAIN: if (!pipe_active) state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d = IDLE;
            acc_d   = '0;
            restart = 1'b0;
        end
        in_ready_d = (state_d == RUN) && (acc_d < run_len_d);
        busy_d     = (state_d == RUN) || (state_d == DRAIN);
        done_d     = (state_d == DONE);
    end

    // Stats see the sample three edges after acceptance; start and clear both wipe them.
    always_comb begin
        cnt_d = cnt_q;
        mm_d  = mm_q;
        sum_d = sum_q;
        max_d = max_q;
`ifdef MUL_ERR_WORST_CAPTURE_EN
        wa_d = wa_q;
        wb_d = wb_q;
`endif
        if (restart || clear_i) begin
            cnt_d = '0;
            mm_d  = '0;
            sum_d = '0;
            max_d = '0;
`ifdef MUL_ERR_WORST_CAPTURE_EN
            wa_d = '0;
            wb_d = '0;
`endif
        end else if (pipe_valid) begin
            cnt_d = CNT_WIDTH'(sat_add(64'(cnt_q), 64'd1, CNT_WIDTH));
            if (err != '0) mm_d = CNT_WIDTH'(sat_add(64'(mm_q), 64'd1, CNT_WIDTH));
            sum_d = ACC_WIDTH'(sat_add(64'(sum_q), 64'(err), ACC_WIDTH));
            if (err > max_q) begin
                max_d = err;
`ifdef MUL_ERR_WORST_CAPTURE_EN
                wa_d = pa;
                wb_d = pb;
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            run_len_q  <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            mm_q       <= '0;
            sum_q      <= '0;
            max_q      <= '0;
`ifdef MUL_ERR_WORST_CAPTURE_EN
            wa_q <= '0;
            wb_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            run_len_q  <= run_len_d;
            acc_q      <= acc_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            mm_q       <= mm_d;
            sum_q      <= sum_d;
            max_q      <= max_d;
`ifdef MUL_ERR_WORST_CAPTURE_EN
            wa_q <= wa_d;
            wb_q <= wb_d;
`endif
        end
    end

    assign in_ready_o     = in_ready_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign sample_cnt_o   = cnt_q;
    assign mismatch_cnt_o = mm_q;
    assign err_sum_o      = sum_q;
    assign err_max_o      = max_q;
`ifdef MUL_ERR_WORST_CAPTURE_EN
    assign worst_a_o = wa_q;
    assign worst_b_o = wb_q;
`endif

endmodule

// File: tb/tb_mul_err_monitor.sv
// Directed plus randomized runs scored against a queue-based model of the run statistics.
// A second instance with an 8-bit accumulator exercises err_sum saturation on the same stimulus.
module tb_mul_err_monitor;
    import mul_err_pkg::*;

    localparam int DW = 8, CW = 32, AW = 40, PW = PROD_W;

    logic          clk = 1'b0, rst_n = 1'b0, clear = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [CW-1:0] run_len = '0;
    logic [DW-1:0] in_a = '0, in_b = '0;
    logic [PW-1:0] in_prod = '0;

    logic          in_ready, busy, done, in_ready8, busy8, done8;
    logic [CW-1:0] sample_cnt, mismatch_cnt, sample_cnt8, mismatch_cnt8;
    logic [AW-1:0] err_sum;
    logic [7:0]    err_sum8;
    logic [PW-1:0] err_max, err_max8;
`ifdef MUL_ERR_WORST_CAPTURE_EN
    logic [DW-1:0] worst_a, worst_b, worst_a8, worst_b8;
`endif

    mul_err_monitor #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .ACC_WIDTH(AW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .start_i(start), .run_len_i(run_len),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_a_i(in_a), .in_b_i(in_b),
        .in_prod_i(in_prod), .busy_o(busy), .done_o(done), .sample_cnt_o(sample_cnt),
        .mismatch_cnt_o(mismatch_cnt), .err_sum_o(err_sum),
`ifdef MUL_ERR_WORST_CAPTURE_EN
        .worst_a_o(worst_a), .worst_b_o(worst_b),
`endif
        .err_max_o(err_max)
    );

    mul_err_monitor #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .ACC_WIDTH(8)) dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .start_i(start), .run_len_i(run_len),
        .in_valid_i(in_valid), .in_ready_o(in_ready8), .in_a_i(in_a), .in_b_i(in_b),
        .in_prod_i(in_prod), .busy_o(busy8), .done_o(done8), .sample_cnt_o(sample_cnt8),
        .mismatch_cnt_o(mismatch_cnt8), .err_sum_o(err_sum8),
`ifdef MUL_ERR_WORST_CAPTURE_EN
        .worst_a_o(worst_a8), .worst_b_o(worst_b8),
`endif
        .err_max_o(err_max8)
    );

    always #5 clk = ~clk;

    typedef struct {int a; int b; int p;} smp_t;
    smp_t stim_q[$], acc_q[$];
    int   n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint abs_err(input smp_t s);
        longint e;
        e = longint'(s.a) * longint'(s.b) - longint'(s.p);
        return (e < 0) ? -e : e;
    endfunction

    function automatic smp_t rnd_smp();
        smp_t s;
        int   ex;
        s.a = int'($urandom_range(0, 255));
        s.b = int'($urandom_range(0, 255));
        ex  = s.a * s.b;
        case ($urandom_range(0, 3))
            0, 1:    s.p = ex;
            2:       s.p = ex + int'($urandom_range(0, 400)) - 200;
            default: s.p = int'($urandom_range(0, 65535));
        endcase
        if (s.p < 0) s.p = 0;
        if (s.p > 65535) s.p = 65535;
        return s;
    endfunction

    // Expected statistics from the list of samples the bench saw accepted.
    task automatic check_stats(input string tag);
        longint sum = 0, mx = 0, e;
        int mm = 0, wa = 0, wb = 0;
        foreach (acc_q[i]) begin
            e = abs_err(acc_q[i]);
            sum += e;
            if (e != 0) mm++;
            if (e > mx) begin mx = e; wa = acc_q[i].a; wb = acc_q[i].b; end
        end
        chk({tag, ".sample_cnt"}, 64'(sample_cnt), 64'(acc_q.size()));
        chk({tag, ".mismatch_cnt"}, 64'(mismatch_cnt), 64'(mm));
        chk({tag, ".err_sum"}, 64'(err_sum), 64'(sum));
        chk({tag, ".err_max"}, 64'(err_max), 64'(mx));
        chk({tag, ".err_sum8"}, 64'(err_sum8), (sum > 255) ? 64'd255 : 64'(sum));
`ifdef MUL_ERR_WORST_CAPTURE_EN
        chk({tag, ".worst_a"}, 64'(worst_a), 64'(wa));
        chk({tag, ".worst_b"}, 64'(worst_b), 64'(wb));
`endif
    endtask

    // gap: 0 valid held, 1 alternating 1010..., 2 random. poke pulses start mid-run.
    task automatic do_run(input string tag, input int len, input int gap, input bit poke);
        int cyc = 0, last = 0, rdy = 0, idx = 0;
        bit acc;
        smp_t cur;
        acc_q.delete();
        run_len = CW'(len);
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy_after_start"}, 64'(busy), 64'd1);
        while (!done && cyc < 300) begin
            cur = (idx < stim_q.size()) ? stim_q[idx] : rnd_smp();
            in_valid = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            in_a    = DW'(cur.a);
            in_b    = DW'(cur.b);
            in_prod = PW'(cur.p);
            start   = poke && (cyc == 2);
            if (start) run_len = CW'(1);
            if (in_ready) rdy++;
            acc = in_valid && in_ready;
            @(posedge clk);
            cyc++;
            if (acc) begin acc_q.push_back(cur); idx++; last = cyc; end
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk({tag, ".done_reached"}, 64'(done), 64'd1);
        chk({tag, ".accepts"}, 64'(acc_q.size()), 64'(len));
        if (gap == 0) chk({tag, ".ready_cycles"}, 64'(rdy), 64'(len));
        if (len > 0) chk({tag, ".done_latency"}, 64'(cyc - last), 64'd4);
        else         chk({tag, ".len0_within3"}, 64'(cyc <= 3), 64'd1);
        chk({tag, ".ready_low_done"}, 64'(in_ready), 64'd0);
        chk({tag, ".busy_low_done"}, 64'(busy), 64'd0);
        chk({tag, ".done8"}, 64'(done8), 64'd1);
        check_stats(tag);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".sample_cnt"}, 64'(sample_cnt), 64'd0);
        chk({tag, ".mismatch_cnt"}, 64'(mismatch_cnt), 64'd0);
        chk({tag, ".err_sum"}, 64'(err_sum), 64'd0);
        chk({tag, ".err_max"}, 64'(err_max), 64'd0);
`ifdef MUL_ERR_WORST_CAPTURE_EN
        chk({tag, ".worst_a"}, 64'(worst_a), 64'd0);
        chk({tag, ".worst_b"}, 64'(worst_b), 64'd0);
`endif
    endtask

    initial begin
        // Reset values
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Exact run
        stim_q = '{'{11, 12, 132}, '{12, 13, 156}, '{13, 14, 182}, '{14, 15, 210}};
        do_run("exact", 4, 0, 1'b0);
        chk("exact.err_sum_const", 64'(err_sum), 64'd0);

        // Error run
        stim_q = '{'{255, 255, 65000}, '{10, 10, 96}, '{3, 3, 9}};
        do_run("errrun", 3, 0, 1'b0);
        chk("errrun.err_sum_const", 64'(err_sum), 64'd29);
        chk("errrun.err_max_const", 64'(err_max), 64'd25);

        // Alternating valid
        stim_q.delete();
        do_run("gaps", 5, 1, 1'b0);

        // Zero-length run
        do_run("len0", 0, 0, 1'b0);

        // Start while busy is ignored
        do_run("poke", 6, 0, 1'b1);

        // Saturation of the narrow accumulator: two errors of 200
        stim_q = '{'{20, 10, 0}, '{20, 10, 0}};
        do_run("sat", 2, 0, 1'b0);
        chk("sat.err_sum8_const", 64'(err_sum8), 64'd255);
        chk("sat.err_sum_const", 64'(err_sum), 64'd400);

        // clear together with start from DONE
        run_len = CW'(3);
        start   = 1'b1;
        clear   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        chk_all_zero("clear_start");
        repeat (2) @(negedge clk);
        chk("clear_start.stays_idle", 64'(busy), 64'd0);

        // clear mid-run flushes samples in flight
        stim_q.delete();
        run_len = CW'(8);
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = 8'd200; in_b = 8'd200; in_prod = 16'd0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        clear    = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (4) @(negedge clk);
        chk_all_zero("clear_mid");

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            stim_q.delete();
            do_run($sformatf("rnd%0d", r), int'($urandom_range(1, 10)), int'($urandom_range(0, 2)), 1'b0);
            @(negedge clk);
        end

        // Asynchronous reset mid-run
        run_len = CW'(10);
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a = 8'd100; in_b = 8'd7; in_prod = 16'd1;
            @(negedge clk);
        end
        chk("midreset.stats_live", 64'(sample_cnt != 0), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("post_reset_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
